// File: rtl/smol_bus_arb_if.sv
// smol_bus_arb_if: one smol four-phase byte-bus link (valid/ready, 16-bit address, 8-bit data).
interface smol_bus_arb_if;
  logic        valid;
  logic        write;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  modport master (output valid, write, addr, wdata, input ready, rdata);
  modport slave  (input valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/smol_bus_arb.sv
// smol_bus_arb: two-master round-robin arbiter for the smol byte bus.
// Define SMOL_ARB_TIMEOUT_EN to abort transfers stalled by the slave for TIMEOUT cycles.
module smol_bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstb,
  smol_bus_arb_if.slave         m0,
  smol_bus_arb_if.slave         m1,
  smol_bus_arb_if.master        s,
  output logic [1:0]            owner,
  output logic                  err,
  input  logic                  err_clr
);
`ifdef SMOL_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, ACK, ABORT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
`endif
  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;
  logic        own_valid, own_write, busy, aborting, gnt0, ret_ready;
  logic [15:0] own_addr;
  logic [7:0]  own_wdata, ret_rdata;
  assign own_valid = (owner_q[0] & m0.valid) | (owner_q[1] & m1.valid);
  assign own_write = owner_q[1] ? m1.write : m0.write;
  assign own_addr  = owner_q[1] ? m1.addr  : m0.addr;
  assign own_wdata = owner_q[1] ? m1.wdata : m0.wdata;
  assign busy      = (state_q == REQ) || (state_q == ACK);
  assign s.valid   = busy & own_valid;
  assign s.write   = busy & own_write;
  assign s.addr    = busy ? own_addr : '0;
  assign s.wdata   = busy ? own_wdata : '0;
  // Return path is combinational so the owner sees ready in the same cycle as the slave.
  assign ret_ready = busy ? s.ready : aborting;
  assign ret_rdata = busy ? s.rdata : (aborting ? 8'hFF : 8'h00);
  assign m0.ready  = owner_q[0] & ret_ready;
  assign m0.rdata  = owner_q[0] ? ret_rdata : '0;
  assign m1.ready  = owner_q[1] & ret_ready;
  assign m1.rdata  = owner_q[1] ? ret_rdata : '0;
  assign owner     = owner_q;
  // last_q=1 means m1 was served last, so m0 wins a tie.
  assign gnt0      = m0.valid & (~m1.valid | last_q);
`ifdef SMOL_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q, timeout;
  assign aborting = state_q == ABORT;
  assign timeout  = busy && (cnt_q == 16'(TIMEOUT - 1));
  assign err      = err_q;
`else
  logic unused_cfg;
  assign aborting   = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{err_clr, TIMEOUT[15:0]};
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (!s.ready && (m0.valid || m1.valid)) begin
        state_d = REQ;
        owner_d = {~gnt0, gnt0};
      end
      REQ: state_d = s.ready ? ACK : REQ;
      ACK: if (!own_valid && !s.ready) begin
        state_d = IDLE;
        owner_d = '0;
        last_d  = owner_q[1];
      end
`ifdef SMOL_ARB_TIMEOUT_EN
      ABORT: state_d = own_valid ? ABORT : DRAIN;
      DRAIN: if (!s.ready) begin
        state_d = IDLE;
        owner_d = '0;
        last_d  = owner_q[1];
      end
`endif
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
`ifdef SMOL_ARB_TIMEOUT_EN
    if (timeout) state_d = ABORT;
`endif
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 1'b1;
`ifdef SMOL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef SMOL_ARB_TIMEOUT_EN
      cnt_q   <= (state_d != state_q || !busy) ? '0 : cnt_q + 16'd1;
      err_q   <= timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
`endif
    end
  end
endmodule

// File: tb/tb_smol_bus_arb.sv
// tb_smol_bus_arb: directed scoreboard bench; expected master responses are queued by the
// stimulus and popped by a monitor on every rising master ready.
module tb_smol_bus_arb;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] owner;
  logic       err;
  logic       stall = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         scnt = 0;
  logic [8:0] exp_q[$];
  smol_bus_arb_if m0_if();
  smol_bus_arb_if m1_if();
  smol_bus_arb_if s_if();
  smol_bus_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rstb(rstb), .m0(m0_if), .m1(m1_if), .s(s_if),
    .owner(owner), .err(err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start(input bit id, input logic w, input logic [15:0] a, input logic [7:0] d);
    if (id) begin
      m1_if.valid = 1'b1; m1_if.write = w; m1_if.addr = a; m1_if.wdata = d;
    end else begin
      m0_if.valid = 1'b1; m0_if.write = w; m0_if.addr = a; m0_if.wdata = d;
    end
  endtask
  task automatic drop(input bit id);
    if (id) begin
      m1_if.valid = 1'b0; m1_if.write = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    end else begin
      m0_if.valid = 1'b0; m0_if.write = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    end
  endtask
  task automatic finish(input bit id);
    int n;
    n = 0;
    while (!(id ? m1_if.ready : m0_if.ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("m%0d_ready_rise_timeout", id), 32'(n < 300), 32'd1);
    drop(id);
    n = 0;
    while ((id ? m1_if.ready : m0_if.ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("m%0d_ready_fall_timeout", id), 32'(n < 300), 32'd1);
  endtask
  task automatic mon(input bit id, input logic [7:0] d);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_resp: got m%0d data %0h expected none", id, d);
    end else begin
      e = exp_q.pop_front();
      chk("resp_id_data", {23'd0, id, d}, {23'd0, e});
    end
  endtask
  // Slave model: answers reads with addr[7:0]^0x59 two observations after s_valid.
  initial begin
    s_if.ready = 1'b0; s_if.rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (!s_if.valid) begin
        scnt = 0;
        if (s_if.ready) begin s_if.ready = 1'b0; s_if.rdata = '0; end
      end else if (!s_if.ready && !stall) begin
        scnt++;
        if (scnt >= 2) begin
          s_if.ready = 1'b1;
          s_if.rdata = s_if.write ? 8'h00 : (s_if.addr[7:0] ^ 8'h59);
          scnt = 0;
        end
      end
    end
  end
  initial begin
    logic p0, p1;
    p0 = 1'b0; p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (m0_if.ready && !p0) mon(1'b0, m0_if.rdata);
      if (m1_if.ready && !p1) mon(1'b1, m1_if.rdata);
      p0 = m0_if.ready; p1 = m1_if.ready;
    end
  end
  initial begin
    int n;
    drop(1'b0); drop(1'b1);
    #2;
    chk("rst_owner_err", {owner, err}, 3'b000);
    chk("rst_slave", {s_if.valid, s_if.write, s_if.addr, s_if.wdata}, 26'd0);
    chk("rst_masters", {m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata}, 18'd0);
    repeat (2) @(posedge clk); #1; rstb = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h5A});
    start(1'b0, 1'b0, 16'h2003, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("read_grant", {owner, s_if.valid, s_if.write, s_if.addr}, {2'b01, 1'b1, 1'b0, 16'h2003});
    chk("read_m1_idle", {m1_if.ready, m1_if.rdata}, 9'd0);
    finish(1'b0);
    @(negedge clk); chk("read_owner_idle", owner, 2'b00);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 8'h00});
    start(1'b1, 1'b1, 16'h2010, 8'hA5);
    @(posedge clk); @(negedge clk);
    chk("write_fwd", {owner, s_if.valid, s_if.write, s_if.addr, s_if.wdata},
        {2'b10, 1'b1, 1'b1, 16'h2010, 8'hA5});
    finish(1'b1);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      exp_q.push_back({1'b0, r == 0 ? 8'h79 : 8'h19});
      exp_q.push_back({1'b1, r == 0 ? 8'h68 : 8'h08});
      start(1'b0, 1'b0, r == 0 ? 16'h2020 : 16'h2040, 8'h00);
      start(1'b1, 1'b0, r == 0 ? 16'h2031 : 16'h2051, 8'h00);
      fork
        begin
          finish(1'b0);
          @(negedge clk); chk("tie_gap_idle", owner, 2'b00);
          @(negedge clk); chk("tie_m1_grant", owner, 2'b10);
        end
        finish(1'b1);
      join
    end
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h00});
    start(1'b0, 1'b1, 16'h20A0, 8'h3C);
    finish(1'b0);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h5A});
    start(1'b0, 1'b0, 16'h2003, 8'h00);
    n = 0;
    while (!m0_if.ready && n < 50) begin @(negedge clk); n++; end
    chk("midack_ready_seen", 32'(n < 50), 32'd1);
    #2 rstb = 1'b0;
    #1;
    chk("midack_s_ready_held", {31'd0, s_if.ready}, 32'd1);
    chk("midack_outputs", {owner, err, s_if.valid, s_if.addr, m0_if.ready, m0_if.rdata},
        28'd0);
    drop(1'b0);
    @(posedge clk); @(negedge clk); @(posedge clk); #1; rstb = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'hD9});
    exp_q.push_back({1'b1, 8'hC8});
    start(1'b0, 1'b0, 16'h2080, 8'h00);
    start(1'b1, 1'b0, 16'h2091, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("post_rst_tie_m0", owner, 2'b01);
    fork
      finish(1'b0);
      finish(1'b1);
    join
    @(posedge clk); #1;
    stall = 1'b1;
    start(1'b0, 1'b0, 16'h2060, 8'h00);
    n = 0;
    while (!s_if.valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_s_valid_seen", 32'(n < 20), 32'd1);
`ifdef SMOL_ARB_TIMEOUT_EN
    exp_q.push_back({1'b0, 8'hFF});
    repeat (7) @(negedge clk);
    chk("to_not_yet", {m0_if.ready, err}, 2'b00);
    @(negedge clk);
    chk("to_abort", {owner, s_if.valid, m0_if.ready, m0_if.rdata, err},
        {2'b01, 1'b0, 1'b1, 8'hFF, 1'b1});
    @(posedge clk); #1; drop(1'b0);
    @(negedge clk); @(negedge clk);
    chk("to_drain", {owner, m0_if.ready}, 3'b010);
    @(negedge clk);
    chk("to_idle_err_sticky", {owner, err}, 3'b001);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk); chk("to_err_clr", {31'd0, err}, 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 8'h28});
    start(1'b1, 1'b0, 16'h2071, 8'h00);
    finish(1'b1);
`else
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    start(1'b1, 1'b0, 16'h2071, 8'h00);
    repeat (10) @(negedge clk);
    chk("stall_hold", {owner, err, m0_if.ready, m1_if.ready}, 5'b01000);
    drop(1'b0); drop(1'b1);
    rstb = 1'b0;
    stall = 1'b0;
    @(posedge clk); #1; rstb = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/smol_bus_arb.md
# smol_bus_arb

Two-master arbiter for the smol four-phase byte bus (valid/ready, 16-bit address, 8-bit data). It sits between the `cpu` (or any bus master such as a loader/DMA) and the memory/device decode in `top`. It grants the single slave port to one master at a time for one complete handshake, with round-robin fairness, and can optionally time out a stalled slave.

## Interface
- `TIMEOUT`, 255: cycles the owner may wait on one `s_ready` edge before the arbiter aborts the transfer (used only with `SMOL_ARB_TIMEOUT_EN`; legal 2..65535).
- `clk`  in  1  clock; all state changes on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `m0_valid`, `m1_valid`  in  1  master request strobe.
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  16  byte address.
- `m0_wdata`, `m1_wdata`  in  8  write data.
- `m0_ready`, `m1_ready`  out  1  handshake acknowledge to master.
- `m0_rdata`, `m1_rdata`  out  8  read data to master.
- `s_valid`, `s_write`  out  1  slave request, direction.
- `s_addr`  out  16  slave address.
- `s_wdata`  out  8  slave write data.
- `s_ready`  in  1  slave acknowledge.
- `s_rdata`  in  8  slave read data.
- `owner`  out  2  one-hot current grant; 2'b00 = idle.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  synchronous clear of `err`.

## Operation
- Protocol per transfer: master raises valid with addr/write/wdata stable -> slave raises ready -> master drops valid -> slave drops ready. Transfer ends on the cycle `s_ready` is sampled low after having been high.
- FSM states: IDLE, REQ (owner valid forwarded, waiting `s_ready`=1), ACK (waiting owner valid=0 then `s_ready`=0), and with the macro ABORT, DRAIN.
- IDLE: if `s_ready`=0 and any valid is high, register grant. Both requesting: grant the master not granted last (`last` pointer, reset to 1 so m0 wins first tie). -> REQ.
- REQ: `s_valid`=owner valid; `s_addr/s_write/s_wdata` muxed from owner. `s_ready`=1 -> ACK.
- ACK: owner `mX_ready`=`s_ready`, `mX_rdata`=`s_rdata`. Owner valid low and `s_ready` low -> IDLE, `last`<=owner, `owner`<=0.
- Non-owner: `mX_ready`=0, `mX_rdata`=0 at all times; its valid is ignored until granted.
- Slave outputs when idle: `s_valid`=0, `s_write`=0, `s_addr`=0, `s_wdata`=0.
- Owner dropping valid in REQ before `s_ready` (protocol violation): `s_valid` falls with it; FSM stays in REQ.
- `err_clr` and timeout in same cycle: set wins.

## Timing
- Reset values: `owner`=0, `err`=0, all `mX_ready`=0, `mX_rdata`=0, `s_valid`=0, `s_write`=0, `s_addr`=0, `s_wdata`=0; FSM IDLE; `last`=1; timeout counter 0.
- Reset mid-transfer: all outputs return to reset values immediately (async); no transfer completion.
- Grant latency: master valid sampled at edge N -> `s_valid` high in cycle after edge N (one cycle added per transfer). Back-to-back: next grant earliest on the edge after `s_ready` sampled low.
- Return path `s_ready`/`s_rdata` -> `mX_ready`/`mX_rdata`: combinational, zero latency. `s_*` request path: combinational from registered grant.

## Configuration
- `SMOL_ARB_TIMEOUT_EN` defined: a 16-bit counter clears on every state change and increments each cycle in REQ and ACK. Reaching `TIMEOUT` -> ABORT: `s_valid`=0, owner `mX_ready`=1, `mX_rdata`=8'hFF, `err`<=1. ABORT: owner valid low -> DRAIN (owner ready 0); DRAIN: `s_ready` low -> IDLE, `last` updated.
- Not defined: no counter, no ABORT/DRAIN; `err` tied 0; `err_clr` ignored; a stalled slave holds the grant forever.

## Test plan
- Single read: m0 reads 0x2003, slave returns 0x5A two cycles after `s_valid` -> `m0_rdata`=0x5A with `m0_ready`, `owner`=01 then 00, `m1_ready` stays 0.
- Tie: m0 and m1 raise valid same edge after reset -> m0 served first, m1 granted on edge after `s_ready` falls; repeat -> order alternates m0,m1,m0,m1.
- Write forwarding: m1 writes 0xA5 to 0x2010 while m0 idle -> `s_write`=1, `s_addr`=0x2010, `s_wdata`=0xA5 one cycle after m1 valid.
- Reset mid-ACK: `rstb` low while `s_ready`=1 -> all outputs 0 same cycle; after release first tie goes to m0.
- Timeout (macro on, `TIMEOUT`=8): slave never responds -> `m0_ready`=1, `m0_rdata`=0xFF 8 cycles after `s_valid`, `err`=1 until `err_clr` pulse; next transfer completes normally.
- Macro off, same stall -> `owner` stays 01, `err`=0, m1 never granted.
